// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word over a
//   valid/ready handshake and emits it one bit per clock on sout, LSB-first
//   (feeds a shift-right register's dr input) or MSB-first (feeds a
//   shift-left register's dl input). frame_start / frame_end mark the first
//   and last bit of each word; hold freezes transmission without losing data.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   din          in   WIDTH  parallel word to transmit
//   din_valid    in   1      din holds a word to transmit
//   din_ready    out  1      word can be accepted this cycle
//   msb_first    in   1      0: LSB first, 1: MSB first (sampled at accept)
//   hold         in   1      1: freeze shifter/counter, emit nothing
//   sout         out  1      serial data bit
//   sout_valid   out  1      sout carries a valid bit this cycle
//   frame_start  out  1      high with the first bit of a word
//   frame_end    out  1      high with the last bit of a word
//   busy         out  1      a word is in flight
//
// Timing model
//   Every serial output is a register loaded at the edge that "emits" a bit,
//   so the first bit is visible the cycle after the accept edge and hold,
//   sampled at an edge, affects the bit that would have followed.
//   ST_LAST is the cycle in which the final bit of a word is on sout: the
//   word is still in flight (busy=1) but nothing is left to shift, so a new
//   word may be accepted, giving gap-free back-to-back frames.
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             msb_first,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,   // no word in flight
        ST_SHIFT,  // bits remain to be emitted (possibly held)
        ST_LAST    // final bit of the word is on sout
    } state_t;

    // Registered state
    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;        // bits not yet emitted, next one at the emit end
    logic             r_dir;          // captured msb_first for the word in flight
    logic [CW-1:0]    r_cnt;          // index of the next bit to emit
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_frame_start;
    logic             r_frame_end;

    // Next-state values
    state_t           w_state_next;
    logic [WIDTH-1:0] w_shreg_next;
    logic             w_dir_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_sout_next;
    logic             w_sout_valid_next;
    logic             w_frame_start_next;
    logic             w_frame_end_next;

    // Working signals
    logic             w_accept;
    logic             w_active;
    logic             w_emit;
    logic             w_bit;
    logic             w_last;
    logic [WIDTH-1:0] w_src_word;
    logic             w_src_dir;
    logic [CW-1:0]    w_src_cnt;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        w_state_next       = ST_IDLE;
        w_shreg_next       = '0;
        w_dir_next         = 1'b0;
        w_cnt_next         = '0;
        w_sout_next        = 1'b0;
        w_sout_valid_next  = 1'b0;
        w_frame_start_next = 1'b0;
        w_frame_end_next   = 1'b0;

        // A word is accepted whenever nothing is left to shift (idle or on
        // the last bit); the accepted word replaces the shifter contents.
        w_accept   = din_valid && (r_state != ST_SHIFT);
        w_src_word = w_accept ? din       : r_shreg;
        w_src_dir  = w_accept ? msb_first : r_dir;
        w_src_cnt  = w_accept ? '0        : r_cnt;

        w_active = w_accept || (r_state == ST_SHIFT);
        w_emit   = w_active && !hold;
        w_bit    = w_src_dir ? w_src_word[WIDTH-1] : w_src_word[0];
        w_last   = (w_src_cnt == LAST_IDX);

        if (w_active) begin
            // Held: everything frozen, sout keeps the bit already shown.
            w_state_next = ST_SHIFT;
            w_shreg_next = w_src_word;
            w_dir_next   = w_src_dir;
            w_cnt_next   = w_src_cnt;
            w_sout_next  = r_sout;

            if (w_emit) begin
                // Shift toward the emitted end, zero fill behind.
                w_shreg_next       = w_src_dir ? (w_src_word << 1) : (w_src_word >> 1);
                w_sout_next        = w_bit;
                w_sout_valid_next  = 1'b1;
                w_frame_start_next = (w_src_cnt == '0);
                w_frame_end_next   = w_last;
                if (w_last) begin
                    // Counter parks at WIDTH-1; it is reloaded on accept.
                    w_state_next = ST_LAST;
                end else begin
                    w_cnt_next = w_src_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state       <= ST_IDLE;
            r_shreg       <= '0;
            r_dir         <= 1'b0;
            r_cnt         <= '0;
            r_sout        <= 1'b0;
            r_sout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_shreg       <= w_shreg_next;
            r_dir         <= w_dir_next;
            r_cnt         <= w_cnt_next;
            r_sout        <= w_sout_next;
            r_sout_valid  <= w_sout_valid_next;
            r_frame_start <= w_frame_start_next;
            r_frame_end   <= w_frame_end_next;
        end
    end

    // Ready and busy are pure decodes of the state register.
    assign din_ready   = (r_state != ST_SHIFT);
    assign busy        = (r_state != ST_IDLE);
    assign sout        = r_sout;
    assign sout_valid  = r_sout_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;

endmodule
